ps2_host_tx: RTL and testbench

- Host-to-device PS/2 transmitter. Sends one command byte to the keyboard, for example LED set (0xED) or reset (0xFF).
- This is the opposite direction to the receive path, which fills the scan-code buffer.
- Drives the open-drain PS/2 clock and data lines through output-enable pins. The top level ties each line low when its enable is 1 and releases it otherwise.
- Sits beside the PS/2 receiver. The receiver must ignore the bus while tx_busy=1.

---
 rtl/ps2_host_tx.sv | 164 ++++++++++++++++
 tb/tb_ps2_host_tx.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, issues a request-to-send,
// shifts one command byte out on device clock falls and checks the device ACK.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_err,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);
    localparam int IW = $clog2(INHIBIT_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        XFER,
        ACK,
        WAIT_IDLE
    } state_t;

    state_t        state, state_nx;
    logic [2:0]    clk_sync;   // [1:0] synchroniser, [2] previous synced value
    logic [1:0]    data_sync;
    logic          clk_s, data_s, fall;
    logic [9:0]    shift, shift_nx;
    logic [3:0]    nbit, nbit_nx;
    logic [IW-1:0] icnt, icnt_nx;
    logic [TW-1:0] wd, wd_nx;
    logic          wd_active, timeout, nack;
    logic          busy_nx, done_nx, err_nx, clk_oe_nx, data_oe_nx;

    // Synchronisers come out of reset at the idle (high) bus level so no
    // spurious edge is seen.
    always_ff @(posedge clock) begin
        if (reset) begin
            clk_sync  <= 3'b111;
            data_sync <= 2'b11;
        end else begin
            clk_sync  <= {clk_sync[1:0], ps2_clk_in};
            data_sync <= {data_sync[0], ps2_data_in};
        end
    end

    assign clk_s  = clk_sync[1];
    assign data_s = data_sync[1];
    assign fall   = clk_sync[2] & ~clk_sync[1];

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            shift       <= '0;
            nbit        <= '0;
            icnt        <= '0;
            wd          <= '0;
            tx_busy     <= 1'b0;
            tx_done     <= 1'b0;
            tx_err      <= 1'b0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
        end else begin
            state       <= state_nx;
            shift       <= shift_nx;
            nbit        <= nbit_nx;
            icnt        <= icnt_nx;
            wd          <= wd_nx;
            tx_busy     <= busy_nx;
            tx_done     <= done_nx;
            tx_err      <= err_nx;
            ps2_clk_oe  <= clk_oe_nx;
            ps2_data_oe <= data_oe_nx;
        end
    end

    // Watchdog restarts on every fall and is held at zero outside the
    // device-clocked states, which also clears it on entry.
    assign wd_active = (state == XFER) || (state == ACK) || (state == WAIT_IDLE);
    assign timeout   = wd_active && !fall && (wd == TW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_nx   = state;
        shift_nx   = shift;
        nbit_nx    = nbit;
        icnt_nx    = icnt;
        busy_nx    = tx_busy;
        done_nx    = 1'b0;
        err_nx     = 1'b0;
        clk_oe_nx  = ps2_clk_oe;
        data_oe_nx = ps2_data_oe;
        nack       = 1'b0;
        wd_nx      = (!wd_active || fall) ? '0 : wd + TW'(1);

        case (state)
            IDLE: begin
                // a request landing on the done/error cycle is dropped
                if (tx_start && !tx_done && !tx_err) begin
                    state_nx   = INHIBIT;
                    shift_nx   = {1'b1, ~^tx_data, tx_data};
                    nbit_nx    = '0;
                    icnt_nx    = '0;
                    busy_nx    = 1'b1;
                    clk_oe_nx  = 1'b1;
                    data_oe_nx = 1'b0;
                end
            end
            INHIBIT: begin
                if (icnt == IW'(INHIBIT_CYCLES - 1)) begin
                    state_nx   = REQ;
                    data_oe_nx = 1'b1;
                end else begin
                    icnt_nx = icnt + IW'(1);
                end
            end
            REQ: begin
                state_nx  = XFER;
                clk_oe_nx = 1'b0;
            end
            XFER: begin
                if (fall) begin
                    data_oe_nx = ~shift[0];
                    shift_nx   = {1'b0, shift[9:1]};
                    nbit_nx    = nbit + 4'd1;
                    if (nbit == 4'd9)
                        state_nx = ACK;
                end
            end
            ACK: begin
                if (fall) begin
                    if (data_s)
                        nack = 1'b1;
                    else
                        state_nx = WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                if (clk_s && data_s) begin
                    state_nx   = IDLE;
                    done_nx    = 1'b1;
                    busy_nx    = 1'b0;
                    data_oe_nx = 1'b0;
                end
            end
            default: state_nx = IDLE;
        endcase

        // a completion in the same cycle as the watchdog expiry still counts
        if ((nack || timeout) && !done_nx) begin
            state_nx   = IDLE;
            err_nx     = 1'b1;
            busy_nx    = 1'b0;
            clk_oe_nx  = 1'b0;
            data_oe_nx = 1'b0;
        end
    end
endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain bus model plus a behavioural PS/2 device
// that clocks the frame in, records the bits it sees and answers with an ACK.
module tb_ps2_host_tx;
    localparam int INH = 50;
    localparam int TMO = 200;
    localparam int HP  = 20;   // device clock half period in system clocks

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_busy, tx_done, tx_err;
    logic       ps2_clk_oe, ps2_data_oe;
    logic       dev_clk, dev_data;
    logic       clk_line, data_line;

    assign clk_line  = dev_clk & ~ps2_clk_oe;
    assign data_line = dev_data & ~ps2_data_oe;

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
        .clock      (clock),
        .reset      (reset),
        .tx_data    (tx_data),
        .tx_start   (tx_start),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done),
        .tx_err     (tx_err),
        .ps2_clk_in (clk_line),
        .ps2_data_in(data_line),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe)
    );

    always #10 clock = ~clock;

    int nvec = 0, nmis = 0;
    int cyc = 0, n_done = 0, n_err = 0, err_cyc = 0, last_fall_cyc = 0;

    always @(posedge clock) cyc <= cyc + 1;
    always @(negedge clock) begin
        if (tx_done) n_done <= n_done + 1;
        if (tx_err) begin
            n_err   <= n_err + 1;
            err_cyc <= cyc;
        end
    end

    typedef struct {
        logic [7:0] data;
        bit         ack;
        bit         par;
        int         done;
        int         err;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Frame as the device should see it: start 0, D0..D7, odd parity, stop 1.
    function automatic logic [10:0] model_frame(input logic [7:0] d);
        int ones;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        return {1'b1, (ones % 2 == 0), d, 1'b0};
    endfunction

    task automatic start_tx(input logic [7:0] d);
        tx_data  = d;
        tx_start = 1'b1;
        @(negedge clock);
        tx_start = 1'b0;
    endtask

    // nfalls > 10 runs the full frame plus the ACK clock.
    task automatic device(input bit ack_low, input int nfalls, output logic [10:0] got);
        got = '0;
        for (int t = 0; t < 500 && !(ps2_clk_oe == 1'b0 && ps2_data_oe == 1'b1); t++)
            @(negedge clock);
        check("req_seen", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd1);
        repeat (HP) @(negedge clock);
        got[0] = data_line;
        for (int i = 1; i <= 10 && i <= nfalls; i++) begin
            dev_clk = 1'b0;
            last_fall_cyc = cyc;
            repeat (HP) @(negedge clock);
            got[i] = data_line;
            dev_clk = 1'b1;
            repeat (HP) @(negedge clock);
        end
        if (nfalls > 10) begin
            dev_data = ~ack_low;
            repeat (5) @(negedge clock);
            dev_clk = 1'b0;
            repeat (HP) @(negedge clock);
            dev_clk = 1'b1;
            repeat (HP) @(negedge clock);
            dev_data = 1'b1;
        end
    endtask

    task automatic wait_idle();
        for (int t = 0; t < 100 && tx_busy; t++) @(negedge clock);
        repeat (3) @(negedge clock);
        check("busy_release", {29'd0, tx_busy, ps2_clk_oe, ps2_data_oe}, 32'd0);
    endtask

    task automatic run_frame(input logic [7:0] d, input bit ack, output logic [10:0] got,
                             output int dd, output int de);
        int d0, e0;
        d0 = n_done;
        e0 = n_err;
        start_tx(d);
        device(ack, 11, got);
        wait_idle();
        dd = n_done - d0;
        de = n_err - e0;
    endtask

    initial begin
        vec_t        tbl[5];
        logic [10:0] got;
        logic [7:0]  d;
        bit          ack;
        int          dd, de, d0, e0, hi, both;

        tbl[0] = '{8'hED, 1'b1, 1'b1, 1, 0};
        tbl[1] = '{8'hFF, 1'b1, 1'b1, 1, 0};
        tbl[2] = '{8'h00, 1'b1, 1'b1, 1, 0};
        tbl[3] = '{8'h01, 1'b1, 1'b0, 1, 0};
        tbl[4] = '{8'hED, 1'b0, 1'b1, 0, 1};

        reset = 1'b1; tx_start = 1'b0; tx_data = 8'h00;
        dev_clk = 1'b1; dev_data = 1'b1;
        repeat (4) @(negedge clock);
        check("reset_outputs", {27'd0, tx_busy, tx_done, tx_err, ps2_clk_oe, ps2_data_oe}, 32'd0);
        reset = 1'b0;
        repeat (4) @(negedge clock);

        for (int i = 0; i < 5; i++) begin
            run_frame(tbl[i].data, tbl[i].ack, got, dd, de);
            check($sformatf("tbl%0d_frame", i), {21'd0, got}, {21'd0, model_frame(tbl[i].data)});
            check($sformatf("tbl%0d_parity", i), {31'd0, got[9]}, {31'd0, tbl[i].par});
            check($sformatf("tbl%0d_done", i), dd, tbl[i].done);
            check($sformatf("tbl%0d_err", i), de, tbl[i].err);
            repeat (10) @(negedge clock);
        end

        // Request latency and inhibit length, then the frame completes.
        check("lat_pre", {31'd0, ps2_clk_oe}, 32'd0);
        d0 = n_done;
        start_tx(8'h96);
        check("lat_clk_oe", {31'd0, ps2_clk_oe}, 32'd1);
        hi = 1; both = 0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clock);
            if (!ps2_clk_oe) break;
            hi++;
            if (ps2_data_oe) both++;
        end
        check("inhibit_len", hi, INH + 1);
        check("req_cycles", both, 1);
        device(1'b1, 11, got);
        wait_idle();
        check("lat_frame", {21'd0, got}, {21'd0, model_frame(8'h96)});
        check("lat_done", n_done - d0, 1);

        // Device stops after fall 4: watchdog fires TMO cycles after the DUT
        // registers that fall (3 edges after the line drops).
        d0 = n_done; e0 = n_err;
        start_tx(8'hA5);
        device(1'b1, 4, got);
        for (int t = 0; t < 400 && n_err == e0; t++) @(negedge clock);
        repeat (3) @(negedge clock);
        check("tmo_err_count", n_err - e0, 1);
        check("tmo_latency", err_cyc - last_fall_cyc, TMO + 3);
        check("tmo_done", n_done - d0, 0);
        check("tmo_release", {29'd0, tx_busy, ps2_clk_oe, ps2_data_oe}, 32'd0);
        repeat (10) @(negedge clock);

        // Second start while busy (with tx_data changed) is ignored, and so is
        // a start on the tx_done cycle.
        d0 = n_done; e0 = n_err;
        start_tx(8'hED);
        repeat (5) @(negedge clock);
        tx_data = 8'h55;
        tx_start = 1'b1;
        @(negedge clock);
        tx_start = 1'b0;
        device(1'b1, 11, got);
        for (int t = 0; t < 100 && !tx_done; t++) @(negedge clock);
        tx_start = 1'b1;
        @(negedge clock);
        tx_start = 1'b0;
        hi = 0;
        for (int t = 0; t < 30; t++) begin
            @(negedge clock);
            if (ps2_clk_oe || tx_busy) hi++;
        end
        check("busy_frame", {21'd0, got}, {21'd0, model_frame(8'hED)});
        check("busy_done", n_done - d0, 1);
        check("busy_err", n_err - e0, 0);
        check("start_on_done", hi, 0);

        // Reset right after fall 5.
        start_tx(8'hED);
        device(1'b1, 4, got);
        dev_clk = 1'b0;
        repeat (4) @(negedge clock);
        check("rst_pre_data_oe", {31'd0, ps2_data_oe}, {31'd0, ~model_frame(8'hED)[5]});
        d0 = n_done; e0 = n_err;
        reset = 1'b1;
        @(negedge clock);
        check("rst_release", {29'd0, tx_busy, ps2_clk_oe, ps2_data_oe}, 32'd0);
        reset = 1'b0;
        dev_clk = 1'b1;
        repeat (10) @(negedge clock);
        check("rst_no_pulse", (n_done - d0) + (n_err - e0), 0);
        run_frame(8'h3C, 1'b1, got, dd, de);
        check("rst_after_frame", {21'd0, got}, {21'd0, model_frame(8'h3C)});
        check("rst_after_done", dd, 1);

        // Random bytes, occasional missing ACK.
        for (int i = 0; i < 8; i++) begin
            d   = 8'($urandom_range(0, 255));
            ack = ($urandom_range(0, 3) != 0);
            run_frame(d, ack, got, dd, de);
            check($sformatf("rnd%0d_frame_%02h", i, d), {21'd0, got}, {21'd0, model_frame(d)});
            check($sformatf("rnd%0d_done", i), dd, ack ? 1 : 0);
            check($sformatf("rnd%0d_err", i), de, ack ? 0 : 1);
            repeat (10) @(negedge clock);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
